// File: rtl/spi_regfile_peripheral.sv
// SPI-slave (mode 0) register file with read-back and framing-error detection.
// Every SPI pin is oversampled in the clk domain; nothing is clocked by sclk.
module spi_regfile_peripheral #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          last_addr,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_CMD_END = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME   = CNT_W'(FRAME_W);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE, ERR} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  state_e                 state_q, state_d, st;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]      snap_q, snap_d, rd_word;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [ADDR_W-1:0]      last_addr_q, wr_addr;
  logic                   wr_pulse_q, frame_err_q, wr_en, err_d;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign wr_addr   = shift_q[DATA_W +: ADDR_W];

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      if (shift_q[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k];
  end

  // st/cnt are the effective state/count this cycle, so an sclk rise in the
  // same detect cycle as the ncs fall is already counted as bit 0 of CMD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    snap_d  = snap_q;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    st      = state_q;
    cnt     = cnt_q;
    if (ncs_rise) begin
      state_d = IDLE;
      if (state_q == DONE)
        wr_en = shift_q[FRAME_W-1] && (32'(wr_addr) < NUM_REGS);
      else if (state_q != IDLE)
        err_d = 1'b1;
    end else begin
      if (state_q == IDLE && ncs_fall) begin
        st      = CMD;
        cnt     = '0;
        state_d = CMD;
        cnt_d   = '0;
      end
      if (sclk_rise) begin
        case (st)
          CMD, WDATA, RDATA: begin
            shift_d = {shift_q[FRAME_W-2:0], copi_s};
            cnt_d   = cnt + 1'b1;
            if (st == CMD && cnt_d == CNT_CMD_END) begin
              state_d = shift_d[ADDR_W] ? WDATA : RDATA;
              snap_d  = '0;
            end else if (st != CMD && cnt_d == CNT_FRAME) begin
              state_d = DONE;
            end
          end
          DONE:    state_d = ERR;
          default: ;
        endcase
      end
      if (sclk_fall && state_q == RDATA)
        snap_d = (cnt_q == CNT_CMD_END) ? rd_word : {snap_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      snap_q      <= '0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      last_addr_q <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      snap_q      <= snap_d;
      wr_pulse_q  <= wr_en;
      frame_err_q <= err_d;
      if (wr_en) last_addr_q <= wr_addr;
      for (int unsigned k = 0; k < NUM_REGS; k++)
        if (wr_en && wr_addr == ADDR_W'(k)) regs_q[k] <= shift_q[DATA_W-1:0];
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign cipo      = (state_q == RDATA) && snap_q[DATA_W-1];
  assign cipo_oe   = ~ncs_s;
  assign wr_pulse  = wr_pulse_q;
  assign frame_err = frame_err_q;
  assign last_addr = last_addr_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: directed test-plan frames followed
// by random frames, checked against an array model of the register file.
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        ncs = 1'b1;
  logic        cipo, cipo_oe, wr_pulse, frame_err;
  logic [39:0] regs;
  logic [6:0]  last_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    logic [6:0]  addr;
    logic [39:0] regs;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] rdq[$];
  logic [7:0] model[5];

  logic [15:0] mon_copi;
  logic [15:0] mon_cipo;
  int          mon_n = 0;

  spi_regfile_peripheral #(
    .NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_pulse(wr_pulse),
    .last_addr(last_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] flat_model();
    logic [39:0] f;
    for (int k = 0; k < 5; k++) f[k*8 +: 8] = model[k];
    return f;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [31:0] w, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      copi = w[i];
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  // Model update and expectations are queued before the frame goes on the wire.
  task automatic send_frame(input logic [15:0] frame, input int nb);
    logic [31:0] w;
    int          a;
    ev_t         e;
    if (nb == 16) begin
      w = {16'd0, frame};
      a = int'(frame[14:8]);
      if (frame[15]) begin
        if (a < 5) begin
          model[a] = frame[7:0];
          e.is_err = 1'b0;
          e.addr   = frame[14:8];
          e.regs   = flat_model();
          evq.push_back(e);
        end
      end else begin
        rdq.push_back(a < 5 ? model[a] : 8'h00);
      end
    end else begin
      if (nb < 16) w = {16'd0, frame} >> (16 - nb);
      else         w = {15'd0, frame, 1'($urandom_range(0, 1))};
      e.is_err = 1'b1;
      e.addr   = '0;
      e.regs   = '0;
      evq.push_back(e);
    end
    ncs = 1'b0;
    wait_clks(HALF);
    drive_bits(w, nb);
    wait_clks(HALF);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clks(12);
    check("regs_after_frame", 64'(regs), 64'(flat_model()));
    check("cipo_oe_idle", 64'(cipo_oe), 64'd0);
    check("cipo_idle", 64'(cipo), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_regs"}, 64'(regs), 64'd0);
    check({tag, "_cipo"}, 64'(cipo), 64'd0);
    check({tag, "_cipo_oe"}, 64'(cipo_oe), 64'd0);
    check({tag, "_wr_pulse"}, 64'(wr_pulse), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_last_addr"}, 64'(last_addr), 64'd0);
  endtask

  // Pulse monitor: every wr_pulse/frame_err cycle consumes one queued event.
  always @(negedge clk) begin
    if (!rst && (wr_pulse || frame_err)) begin
      if (evq.size() == 0) begin
        check("unexpected_pulse", {62'd0, wr_pulse, frame_err}, 64'd0);
      end else begin
        ev_t e;
        e = evq.pop_front();
        check("wr_pulse", 64'(wr_pulse), 64'(!e.is_err));
        check("frame_err", 64'(frame_err), 64'(e.is_err));
        if (!e.is_err) begin
          check("last_addr", 64'(last_addr), 64'(e.addr));
          check("regs_at_pulse", 64'(regs), 64'(e.regs));
        end
      end
    end
  end

  // Bus monitor: snoops pins at each sclk rise and checks read data at ncs rise.
  always @(posedge sclk) begin
    if (!ncs && !rst) begin
      check("cipo_oe_in_frame", 64'(cipo_oe), 64'd1);
      if (mon_n < 8) check("cipo_cmd_phase", 64'(cipo), 64'd0);
      mon_copi = {mon_copi[14:0], copi};
      mon_cipo = {mon_cipo[14:0], cipo};
      mon_n++;
    end
  end

  always @(posedge ncs) begin
    if (mon_n == 16 && !mon_copi[15]) begin
      if (rdq.size() == 0) begin
        check("unexpected_read", 64'(mon_cipo[7:0]), 64'hdead);
      end else begin
        logic [7:0] exp_rd;
        exp_rd = rdq.pop_front();
        check("read_data", 64'(mon_cipo[7:0]), 64'(exp_rd));
      end
    end
    mon_n = 0;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 5; k++) model[k] = 8'h00;
    wait_clks(3);
    check_reset_values("reset_held");
    rst = 1'b0;
    wait_clks(5);
    check_reset_values("reset_released");

    send_frame(16'h82A5, 16);
    check("reg2_written", 64'(regs[23:16]), 64'hA5);
    send_frame(16'h0200, 16);
    send_frame(16'h893C, 16);
    send_frame(16'h0900, 16);
    send_frame(16'h8133, 10);
    send_frame(16'h8011, 16);
    check("reg0_written", 64'(regs[7:0]), 64'h11);
    send_frame(16'h8455, 17);

    // Reset in the data phase of a write to addr 1; the frame is lost.
    ncs = 1'b0;
    wait_clks(HALF);
    drive_bits(32'h0000_081C, 12);
    rst = 1'b1;
    wait_clks(3);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clks(3);
    for (int k = 0; k < 5; k++) model[k] = 8'h00;
    check_reset_values("reset_midframe");
    rst = 1'b0;
    wait_clks(10);
    check_reset_values("after_midframe");
    send_frame(16'h81FF, 16);
    check("reg1_written", 64'(regs[15:8]), 64'hFF);

    for (int it = 0; it < 45; it++) begin
      logic [15:0] fr;
      int          sel;
      fr  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 9)), 8'($urandom)};
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      send_frame(fr, int'($urandom_range(1, 15)));
      else if (sel == 1) send_frame(fr, 17);
      else               send_frame(fr, 16);
    end

    wait_clks(10);
    check("events_drained", 64'(evq.size()), 64'd0);
    check("reads_drained", 64'(rdq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI-slave register file: next generation of the onboarding SPI peripheral, with configurable register count and widths, read-back over CIPO, and framing-error detection. Sits between the TinyTapeout input pins (SCLK, COPI, nCS on `ui_in`) and downstream peripherals such as the PWM block, which consume the flat register bus. All SPI pins are oversampled in the `clk` domain; no logic is clocked by SCLK.

## Interface
- `NUM_REGS`, 5, number of implemented registers (addresses 0..NUM_REGS-1)
- `ADDR_W`, 7, address field width in the frame
- `DATA_W`, 8, register and data-field width
- `SYNC_STAGES`, 2, synchroniser flops per SPI input (≥2)
- `clk  in  1  system clock; one clock domain for the whole block`
- `rst  in  1  reset, asynchronous and active-high`
- `sclk  in  1  SPI clock pin, mode 0 (CPOL=0, CPHA=0)`
- `copi  in  1  SPI data in, MSB first`
- `ncs  in  1  SPI chip select, active-low`
- `cipo  out  1  SPI data out`
- `cipo_oe  out  1  output enable for cipo; high while synchronised ncs is low`
- `regs  out  NUM_REGS*DATA_W  flat register bus; register k at [k*DATA_W +: DATA_W]`
- `wr_pulse  out  1  one-cycle strobe when a register is written`
- `last_addr  out  ADDR_W  address of the most recent committed write`
- `frame_err  out  1  one-cycle strobe on aborted or overlong frame`

## Operation
- Frame = 1 R/W bit (1 = write, 0 = read) + ADDR_W address bits + DATA_W data bits; FRAME_W = 1+ADDR_W+DATA_W (16 by default). All fields MSB first.
- Inputs pass through SYNC_STAGES flops; one extra flop on sclk/ncs for edge detect. COPI is sampled on detected sclk rising edges only.
- FSM states:
  - IDLE: ncs high. ncs fall → CMD, bit counter cleared.
  - CMD: shift R/W and address. After bit 1+ADDR_W → WDATA (write) or RDATA (read).
  - WDATA: shift DATA_W bits into a write buffer.
  - RDATA: count DATA_W bits; cipo driven from a snapshot shift register.
  - DONE: FRAME_W bits received; waiting for ncs rise.
  - ERR: more than FRAME_W rising edges; ignore further bits until ncs rise.
- ncs rise in DONE after write with address < NUM_REGS: register updated, wr_pulse=1, last_addr=address. Otherwise no register change, no wr_pulse.
- ncs rise in CMD/WDATA/RDATA (short frame) or ERR: frame_err=1, no write. Always → IDLE.
- Read: on the sclk falling edge after the last address bit, snapshot = register[addr] (0 if addr ≥ NUM_REGS); cipo = snapshot MSB. Each later falling edge shifts the next bit out. Outside RDATA, cipo=0.
- Writes to out-of-range addresses are a legal frame: silently dropped, no frame_err.

## Timing
- Reset values: regs all 0, cipo 0, cipo_oe 0, wr_pulse 0, last_addr 0, frame_err 0, FSM IDLE, synchronisers 0 except the ncs chain, which resets to 1.
- Pin edge → detected edge: SYNC_STAGES+1 clk cycles.
- ncs rise detected → regs/last_addr updated and wr_pulse high on the next clk edge. wr_pulse and frame_err last exactly 1 cycle.
- cipo changes 1 cycle after a detected falling edge, so it is valid well before the next rising edge.
- SCLK high and low phases each ≥ SYNC_STAGES+2 clk periods. Faster SCLK is out of spec.
- ncs fall and first sclk rise in the same detect cycle: the transition to CMD happens first; the edge counts as bit 0.
- Reset asserted mid-frame: immediate return to reset values. The in-flight frame is lost; the next ncs fall starts a fresh frame.

## Test plan
- Write 0x82,0xA5 (write, addr 2, data 0xA5) → regs[23:16]=0xA5, other regs 0, one wr_pulse, last_addr=2.
- After the above, read 0x02,0x00 → cipo bits across data phase 1,0,1,0,0,1,0,1; cipo_oe high only while ncs low; regs unchanged.
- Write 0x89,0x3C (addr 9 ≥ NUM_REGS) → no reg change, no wr_pulse, no frame_err; read addr 9 returns 0x00.
- Write frame raised after 10 bits → no reg change, frame_err one cycle; a following complete write to addr 0 with 0x11 succeeds.
- 17-bit frame (valid 16 bits + 1 extra) → frame_err, no write.
- Assert rst during WDATA of a write to addr 1 → all regs 0, outputs at reset values; a next full write 0x81,0xFF → regs[15:8]=0xFF.
